// File: rtl/traffic_pkg.sv
// Shared lamp codes and controller state encoding for the light blocks.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package traffic_pkg;

    typedef enum logic [1:0] {
        L_OFF    = 2'b00,
        L_RED    = 2'b01,
        L_YELLOW = 2'b10,
        L_GREEN  = 2'b11
    } light_t;

    typedef enum logic [3:0] {
        S_OFF,
        S_RED_A,
        S_NS_GRN,
        S_NS_FLK,
        S_NS_YEL,
        S_RED_B,
        S_EW_GRN,
        S_EW_FLK,
        S_EW_YEL
    } isc_state_t;

    // Green state for a direction bit (0 = NS, 1 = EW).
    function automatic isc_state_t grn_of(input logic dir);
        return dir ? S_EW_GRN : S_NS_GRN;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counting phase timer: load wins, otherwise decrements on en, saturates at zero.
// Latency: count reflects load/en the cycle after they are asserted.
// Backpressure: none; en low simply freezes the count.
//
// Ports: clk, reset (sync, active-high), load, load_val[TW], en -> count[TW], expired (count == 0).
module phase_timer #(
    parameter int TW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic [TW-1:0] count,
    output logic          expired
);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign count   = r_count;
    assign expired = (r_count == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way (NS/EW) intersection sequencer with ped walk latches and emergency preempt.
// Latency: Moore outputs; a phase change shows the cycle after the expiring tick.
// Backpressure: none; tick gates all timing, start is only looked at in OFF.
//
// Ports: clk, reset (sync, active-high), tick, start, ped_req_ns/ew, preempt, preempt_dir
//        -> L_ns/L_ew (2-bit lamp codes), walk_ns/walk_ew, busy.
module intersection_ctrl #(
    parameter int TW            = 5,
    parameter int GREEN_TICKS   = 30,
    parameter int FLICKER_TICKS = 5,
    parameter int YELLOW_TICKS  = 3,
    parameter int ALLRED_TICKS  = 2,
    parameter int WALK_TICKS    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    input  logic       preempt,
    input  logic       preempt_dir,
    output logic [1:0] L_ns,
    output logic [1:0] L_ew,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic       busy
);
    import traffic_pkg::*;

    localparam int MAXV    = (1 << TW) - 1;
    localparam int GRN_DUR = GREEN_TICKS - FLICKER_TICKS;

    localparam logic [TW-1:0] LD_GRN   = TW'(GRN_DUR - 1);
    localparam logic [TW-1:0] LD_FLK   = TW'(FLICKER_TICKS - 1);
    localparam logic [TW-1:0] LD_YEL   = TW'(YELLOW_TICKS - 1);
    localparam logic [TW-1:0] LD_RED   = TW'(ALLRED_TICKS - 1);
    localparam logic [TW-1:0] WALK_LEN = TW'(WALK_TICKS);

    if (GREEN_TICKS > MAXV || FLICKER_TICKS > MAXV || YELLOW_TICKS > MAXV ||
        ALLRED_TICKS > MAXV || WALK_TICKS > MAXV) begin : g_cfg_width
        $error("intersection_ctrl: a duration parameter does not fit in TW bits");
    end
    if (FLICKER_TICKS < 1 || GREEN_TICKS <= FLICKER_TICKS || YELLOW_TICKS < 1 ||
        ALLRED_TICKS < 1 || WALK_TICKS > GRN_DUR) begin : g_cfg_range
        $error("intersection_ctrl: inconsistent phase durations");
    end

    isc_state_t    r_state;
    isc_state_t    w_state_next;
    logic          w_hold;
    logic          w_step;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic [TW-1:0] w_count;
    logic          w_expired;
    logic [TW-1:0] w_elapsed;
    logic          r_flk;
    logic          r_ped_ns, r_ped_ew;
    logic          r_walk_ns, r_walk_ew;
    light_t        w_l_ns, w_l_ew;

    phase_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (tick & ~w_hold),
        .count    (w_count),
        .expired  (w_expired)
    );

    assign w_step = tick & w_expired;

    // Next state. A preempt jump out of green/flicker takes priority over an
    // expiring tick in the same cycle; a held green never advances.
    always_comb begin
        w_state_next = r_state;
        w_hold       = 1'b0;
        case (r_state)
            S_OFF:   if (start) w_state_next = S_RED_A;
            S_RED_A: if (w_step) w_state_next = preempt ? grn_of(preempt_dir) : S_NS_GRN;
            S_RED_B: if (w_step) w_state_next = preempt ? grn_of(preempt_dir) : S_EW_GRN;
            S_NS_GRN: begin
                if (preempt && preempt_dir)  w_state_next = S_NS_YEL;
                else if (preempt)            w_hold       = 1'b1;
                else if (w_step)             w_state_next = S_NS_FLK;
            end
            S_NS_FLK: if ((preempt && preempt_dir) || w_step) w_state_next = S_NS_YEL;
            S_NS_YEL: if (w_step) w_state_next = S_RED_B;
            S_EW_GRN: begin
                if (preempt && !preempt_dir) w_state_next = S_EW_YEL;
                else if (preempt)            w_hold       = 1'b1;
                else if (w_step)             w_state_next = S_EW_FLK;
            end
            S_EW_FLK: if ((preempt && !preempt_dir) || w_step) w_state_next = S_EW_YEL;
            S_EW_YEL: if (w_step) w_state_next = S_RED_A;
            default:  w_state_next = S_OFF;
        endcase
    end

    // Every state change is an entry, so the timer reloads on any transition.
    assign w_load = (w_state_next != r_state);

    always_comb begin
        w_load_val = '0;
        case (w_state_next)
            S_NS_GRN, S_EW_GRN: w_load_val = LD_GRN;
            S_NS_FLK, S_EW_FLK: w_load_val = LD_FLK;
            S_NS_YEL, S_EW_YEL: w_load_val = LD_YEL;
            S_RED_A,  S_RED_B:  w_load_val = LD_RED;
            default:            w_load_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flicker phase: cleared on any transition, toggled on ticks while flickering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flk <= 1'b0;
        end else if (w_load) begin
            r_flk <= 1'b0;
        end else if (tick && (r_state == S_NS_FLK || r_state == S_EW_FLK)) begin
            r_flk <= ~r_flk;
        end
    end

    // Ped latches. On green entry the latch (including a request in that very
    // cycle) is moved into the walk grant; later requests wait for the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ped_ns  <= 1'b0;
            r_ped_ew  <= 1'b0;
            r_walk_ns <= 1'b0;
            r_walk_ew <= 1'b0;
        end else if (r_state != S_OFF) begin
            if (w_state_next == S_NS_GRN && r_state != S_NS_GRN) begin
                r_walk_ns <= r_ped_ns | ped_req_ns;
                r_ped_ns  <= 1'b0;
            end else begin
                r_ped_ns  <= r_ped_ns | ped_req_ns;
            end
            if (w_state_next == S_EW_GRN && r_state != S_EW_GRN) begin
                r_walk_ew <= r_ped_ew | ped_req_ew;
                r_ped_ew  <= 1'b0;
            end else begin
                r_ped_ew  <= r_ped_ew | ped_req_ew;
            end
        end
    end

    // Ticks consumed so far in green; held ticks do not count.
    assign w_elapsed = LD_GRN - w_count;

    always_comb begin
        w_l_ns = L_RED;
        w_l_ew = L_RED;
        case (r_state)
            S_OFF:    begin w_l_ns = L_OFF; w_l_ew = L_OFF; end
            S_NS_GRN: w_l_ns = L_GREEN;
            S_NS_FLK: w_l_ns = r_flk ? L_OFF : L_GREEN;
            S_NS_YEL: w_l_ns = L_YELLOW;
            S_EW_GRN: w_l_ew = L_GREEN;
            S_EW_FLK: w_l_ew = r_flk ? L_OFF : L_GREEN;
            S_EW_YEL: w_l_ew = L_YELLOW;
            default:  ;
        endcase
    end

    assign L_ns    = w_l_ns;
    assign L_ew    = w_l_ew;
    assign walk_ns = (r_state == S_NS_GRN) && r_walk_ns && (w_elapsed < WALK_LEN);
    assign walk_ew = (r_state == S_EW_GRN) && r_walk_ew && (w_elapsed < WALK_LEN);
    assign busy    = (r_state != S_OFF);

endmodule

// File: tb/tb_intersection_ctrl.sv
// Randomized bench: a direction/stage reference model predicts lamps, walk and busy every cycle.
module tb_intersection_ctrl;

    localparam int P_GRN  = 6;
    localparam int P_FLK  = 2;
    localparam int P_YEL  = 2;
    localparam int P_RED  = 1;
    localparam int P_WALK = 3;

    // model stages
    localparam int ST_RED = 0;
    localparam int ST_GRN = 1;
    localparam int ST_FLK = 2;
    localparam int ST_YEL = 3;

    logic       clk = 1'b0;
    logic       reset, tick, start, ped_req_ns, ped_req_ew, preempt, preempt_dir;
    logic [1:0] L_ns, L_ew;
    logic       walk_ns, walk_ew, busy;

    int n_vec = 0;
    int n_err = 0;

    intersection_ctrl #(
        .TW(5), .GREEN_TICKS(P_GRN), .FLICKER_TICKS(P_FLK),
        .YELLOW_TICKS(P_YEL), .ALLRED_TICKS(P_RED), .WALK_TICKS(P_WALK)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
        .preempt(preempt), .preempt_dir(preempt_dir),
        .L_ns(L_ns), .L_ew(L_ew), .walk_ns(walk_ns), .walk_ew(walk_ew), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: running flag, active (or next-scheduled) direction,
    // stage, ticks left in the stage, green ticks used, flicker toggles.
    bit m_on;
    int m_dir;
    int m_stage;
    int m_left;
    int m_elapsed;
    int m_toggles;
    bit m_ped   [2];
    bit m_grant [2];

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        bit req [2];
        int nd;
        bit enter_grn;
        req[0] = ped_req_ns;
        req[1] = ped_req_ew;
        if (reset) begin
            m_on = 0;
            m_ped[0] = 0; m_ped[1] = 0;
            m_grant[0] = 0; m_grant[1] = 0;
            return;
        end
        if (!m_on) begin
            if (start) begin
                m_on = 1; m_stage = ST_RED; m_dir = 0; m_left = P_RED;
            end
            return;
        end
        enter_grn = 0;
        nd = m_dir;
        if ((m_stage == ST_GRN || m_stage == ST_FLK) && preempt && int'(preempt_dir) != m_dir) begin
            m_stage = ST_YEL;
            m_left  = P_YEL;
        end else if (m_stage == ST_GRN && preempt) begin
            // green held for the preempting direction
        end else if (tick) begin
            m_left--;
            if (m_stage == ST_GRN) m_elapsed++;
            if (m_stage == ST_FLK) m_toggles++;
            if (m_left == 0) begin
                case (m_stage)
                    ST_RED: begin
                        nd = preempt ? int'(preempt_dir) : m_dir;
                        m_stage = ST_GRN; m_left = P_GRN - P_FLK; m_elapsed = 0; enter_grn = 1;
                    end
                    ST_GRN: begin m_stage = ST_FLK; m_left = P_FLK; m_toggles = 0; end
                    ST_FLK: begin m_stage = ST_YEL; m_left = P_YEL; end
                    default: begin m_stage = ST_RED; m_left = P_RED; nd = 1 - m_dir; end
                endcase
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (enter_grn && d == nd) begin
                m_grant[d] = m_ped[d] | req[d];
                m_ped[d]   = 0;
            end else begin
                m_ped[d] = m_ped[d] | req[d];
            end
        end
        m_dir = nd;
    endtask

    task automatic compare();
        logic [1:0] act, e_ns, e_ew;
        logic       e_wns, e_wew;
        e_ns = 2'b00; e_ew = 2'b00; e_wns = 1'b0; e_wew = 1'b0;
        if (m_on) begin
            e_ns = 2'b01; e_ew = 2'b01;
            if (m_stage != ST_RED) begin
                if (m_stage == ST_GRN)      act = 2'b11;
                else if (m_stage == ST_YEL) act = 2'b10;
                else                        act = (m_toggles % 2 == 1) ? 2'b00 : 2'b11;
                if (m_dir == 0) e_ns = act; else e_ew = act;
                if (m_stage == ST_GRN && m_grant[m_dir] && m_elapsed < P_WALK) begin
                    if (m_dir == 0) e_wns = 1'b1; else e_wew = 1'b1;
                end
            end
        end
        chk("L_ns",    {2'b00, L_ns},    {2'b00, e_ns});
        chk("L_ew",    {2'b00, L_ew},    {2'b00, e_ew});
        chk("walk_ns", {3'b000, walk_ns}, {3'b000, e_wns});
        chk("walk_ew", {3'b000, walk_ew}, {3'b000, e_wew});
        chk("busy",    {3'b000, busy},    {3'b000, m_on});
    endtask

    // tick_div: 0 = random tick, N = tick every Nth cycle. Percentages per
    // cycle for ped pulses and preempt toggles; reset chance is per mille.
    task automatic run(input int n, input int tick_div, input int ped_pct,
                       input int pre_pct, input int rst_pm);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare();
            reset      = ($urandom_range(0, 999) < rst_pm);
            start      = ($urandom_range(0, 99) < 20);
            tick       = (tick_div == 0) ? 1'($urandom_range(0, 1)) : ((i % tick_div) == 0);
            ped_req_ns = ($urandom_range(0, 99) < ped_pct);
            ped_req_ew = ($urandom_range(0, 99) < ped_pct);
            if ($urandom_range(0, 99) < pre_pct) preempt = ~preempt;
            if ($urandom_range(0, 9) == 0) preempt_dir = 1'($urandom_range(0, 1));
            @(posedge clk);
            model_step();
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b1; start = 1'b0;
        ped_req_ns = 1'b0; ped_req_ew = 1'b0; preempt = 1'b0; preempt_dir = 1'b0;
        m_on = 0; m_dir = 0; m_stage = ST_RED; m_left = 0; m_elapsed = 0; m_toggles = 0;
        m_ped[0] = 0; m_ped[1] = 0; m_grant[0] = 0; m_grant[1] = 0;
        repeat (2) begin
            @(posedge clk);
            model_step();
        end
        run(60,   1, 0, 0, 0);   // plain cycle, tick every cycle
        run(150,  3, 0, 0, 0);   // slow timebase
        run(600,  1, 6, 0, 0);   // pedestrian requests
        run(1500, 0, 5, 4, 0);   // preempt episodes, random ticks
        run(1500, 1, 4, 3, 4);   // everything plus occasional reset
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
